// File: rtl/pc_fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its driver (top level or bench).
// master: drives Start/stall, the decoder branch fields and the LUT write port;
//         observes PC, fetch_valid and Done.
// slave : the sequencer itself.
interface pc_fetch_sequencer_if #(
  parameter int PC_W = 10
);
  logic            Start;
  logic            stall;
  logic            jump_en;
  logic            immOrLUT;
  logic [3:0]      target_idx;
  logic            lut_we;
  logic [3:0]      lut_waddr;
  logic [PC_W-1:0] lut_wdata;
  logic [PC_W-1:0] PC;
  logic            fetch_valid;
  logic            Done;

  modport master (
    output Start, stall, jump_en, immOrLUT, target_idx,
           lut_we, lut_waddr, lut_wdata,
    input  PC, fetch_valid, Done
  );

  modport slave (
    input  Start, stall, jump_en, immOrLUT, target_idx,
           lut_we, lut_waddr, lut_wdata,
    output PC, fetch_valid, Done
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter and fetch sequencer feeding the control decoder.
// Chooses the next PC from sequential increment, a PC-relative signed 4-bit
// offset, or a 16-entry branch-target LUT, and runs the Start/Done handshake.
// Ports:
//   Clk   - rising-edge clock
//   Reset - synchronous, active-high; clears state, PC and the LUT
//   bus   - slave side of pc_fetch_sequencer_if (handshake, branch inputs,
//           LUT write port, PC/fetch_valid/Done outputs)
module pc_fetch_sequencer #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16,
  parameter int LAST_ADDR = 1023
) (
  input  logic                  Clk,
  input  logic                  Reset,
  pc_fetch_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] lut_q [LUT_DEPTH];
  logic [PC_W-1:0] lut_d [LUT_DEPTH];

  logic [PC_W-1:0] rel_off;
  logic [PC_W-1:0] jump_tgt;

  assign rel_off  = {{(PC_W-4){bus.target_idx[3]}}, bus.target_idx};
  // LUT read uses the registered array, so a same-cycle write is not seen.
  assign jump_tgt = bus.immOrLUT ? lut_q[bus.target_idx] : pc_q + rel_off;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lut_d   = lut_q;

    if (bus.lut_we) begin
      lut_d[bus.lut_waddr] = bus.lut_wdata;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          if (bus.jump_en) begin
            pc_d = jump_tgt;
          end else if (pc_q == PC_W'(LAST_ADDR)) begin
            state_d = DONE;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lut_q   <= lut_d;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.Done        = (state_q == DONE);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;
  localparam int PC_W = 10;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_err;

  pc_fetch_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_fetch_sequencer #(
    .PC_W     (PC_W),
    .LUT_DEPTH(16),
    .LAST_ADDR(5)
  ) u_dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Advance one edge; outputs are sampled and inputs changed 1 ns later.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Start      = 1'b0;
    bus.stall      = 1'b0;
    bus.jump_en    = 1'b0;
    bus.immOrLUT   = 1'b0;
    bus.target_idx = 4'd0;
    bus.lut_we     = 1'b0;
    bus.lut_waddr  = 4'd0;
    bus.lut_wdata  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    step();
    step();
    n_cmp++;
    if ({bus.PC, bus.fetch_valid, bus.Done} !== {10'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_state: got PC=%0d fv=%b done=%b, required PC=0 fv=0 done=0",
               bus.PC, bus.fetch_valid, bus.Done);
      n_err++;
    end
    Reset = 1'b0;
    step();
    n_cmp++;
    if ({bus.PC, bus.fetch_valid, bus.Done} !== {10'd0, 1'b0, 1'b0}) begin
      $display("FAIL idle_hold: got PC=%0d fv=%b done=%b, required PC=0 fv=0 done=0",
               bus.PC, bus.fetch_valid, bus.Done);
      n_err++;
    end
  endtask

  task automatic test_sequential();
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      n_cmp++;
      if ({bus.PC, bus.fetch_valid, bus.Done} !== {PC_W'(i), 1'b1, 1'b0}) begin
        $display("FAIL seq_pc%0d: got PC=%0d fv=%b done=%b, required PC=%0d fv=1 done=0",
                 i, bus.PC, bus.fetch_valid, bus.Done, i);
        n_err++;
      end
      if (i < 5) step();
    end
    step();
    n_cmp++;
    if ({bus.PC, bus.fetch_valid, bus.Done} !== {10'd5, 1'b0, 1'b1}) begin
      $display("FAIL seq_done: got PC=%0d fv=%b done=%b, required PC=5 fv=0 done=1",
               bus.PC, bus.fetch_valid, bus.Done);
      n_err++;
    end
    step();
    n_cmp++;
    if ({bus.PC, bus.fetch_valid, bus.Done} !== {10'd5, 1'b0, 1'b1}) begin
      $display("FAIL done_hold: got PC=%0d fv=%b done=%b, required PC=5 fv=0 done=1",
               bus.PC, bus.fetch_valid, bus.Done);
      n_err++;
    end
  endtask

  task automatic test_done_restart();
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    n_cmp++;
    if ({bus.PC, bus.fetch_valid, bus.Done} !== {10'd0, 1'b1, 1'b0}) begin
      $display("FAIL done_restart: got PC=%0d fv=%b done=%b, required PC=0 fv=1 done=0",
               bus.PC, bus.fetch_valid, bus.Done);
      n_err++;
    end
  endtask

  task automatic test_start_ignored();
    step();
    step();
    step();
    n_cmp++;
    if (bus.PC !== 10'd3) begin
      $display("FAIL pre_start_pc: got PC=%0d, required PC=3", bus.PC);
      n_err++;
    end
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    n_cmp++;
    if ({bus.PC, bus.fetch_valid} !== {10'd4, 1'b1}) begin
      $display("FAIL start_in_run: got PC=%0d fv=%b, required PC=4 fv=1",
               bus.PC, bus.fetch_valid);
      n_err++;
    end
  endtask

  task automatic test_rel_jump();
    bus.jump_en    = 1'b1;
    bus.immOrLUT   = 1'b0;
    bus.target_idx = 4'b0110;
    step();
    n_cmp++;
    if (bus.PC !== 10'd10) begin
      $display("FAIL rel_plus6: got PC=%0d, required PC=10", bus.PC);
      n_err++;
    end
    bus.target_idx = 4'b1101;
    step();
    n_cmp++;
    if (bus.PC !== 10'd7) begin
      $display("FAIL rel_minus3: got PC=%0d, required PC=7", bus.PC);
      n_err++;
    end
    bus.target_idx = 4'b0000;
    step();
    n_cmp++;
    if (bus.PC !== 10'd7) begin
      $display("FAIL rel_self: got PC=%0d, required PC=7", bus.PC);
      n_err++;
    end
    // LUT[0] is still 0 from reset, so this lands on PC 0.
    bus.immOrLUT   = 1'b1;
    bus.target_idx = 4'd0;
    step();
    n_cmp++;
    if (bus.PC !== 10'd0) begin
      $display("FAIL lut_zero: got PC=%0d, required PC=0", bus.PC);
      n_err++;
    end
    bus.immOrLUT   = 1'b0;
    bus.target_idx = 4'b1111;
    step();
    n_cmp++;
    if (bus.PC !== 10'd1023) begin
      $display("FAIL rel_wrap_down: got PC=%0d, required PC=1023", bus.PC);
      n_err++;
    end
    bus.jump_en = 1'b0;
    step();
    n_cmp++;
    if ({bus.PC, bus.fetch_valid} !== {10'd0, 1'b1}) begin
      $display("FAIL inc_wrap_up: got PC=%0d fv=%b, required PC=0 fv=1",
               bus.PC, bus.fetch_valid);
      n_err++;
    end
  endtask

  task automatic test_lut();
    bus.lut_we    = 1'b1;
    bus.lut_waddr = 4'd3;
    bus.lut_wdata = 10'd200;
    step();
    bus.lut_waddr = 4'd1;
    bus.lut_wdata = 10'd6;
    step();
    bus.lut_waddr = 4'd2;
    bus.lut_wdata = 10'd42;
    step();
    bus.lut_we = 1'b0;
    n_cmp++;
    if (bus.PC !== 10'd3) begin
      $display("FAIL lut_write_seq: got PC=%0d, required PC=3", bus.PC);
      n_err++;
    end
    bus.jump_en    = 1'b1;
    bus.immOrLUT   = 1'b1;
    bus.target_idx = 4'd3;
    step();
    n_cmp++;
    if (bus.PC !== 10'd200) begin
      $display("FAIL lut_jump: got PC=%0d, required PC=200", bus.PC);
      n_err++;
    end
    bus.lut_we    = 1'b1;
    bus.lut_waddr = 4'd3;
    bus.lut_wdata = 10'd300;
    step();
    bus.lut_we = 1'b0;
    n_cmp++;
    if (bus.PC !== 10'd200) begin
      $display("FAIL lut_same_cycle: got PC=%0d, required PC=200 (old entry)", bus.PC);
      n_err++;
    end
    step();
    n_cmp++;
    if (bus.PC !== 10'd300) begin
      $display("FAIL lut_new_value: got PC=%0d, required PC=300", bus.PC);
      n_err++;
    end
  endtask

  task automatic test_stall();
    bus.jump_en    = 1'b1;
    bus.immOrLUT   = 1'b1;
    bus.target_idx = 4'd1;
    step();
    n_cmp++;
    if (bus.PC !== 10'd6) begin
      $display("FAIL stall_setup: got PC=%0d, required PC=6", bus.PC);
      n_err++;
    end
    bus.stall      = 1'b1;
    bus.immOrLUT   = 1'b0;
    bus.target_idx = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({bus.PC, bus.fetch_valid} !== {10'd6, 1'b1}) begin
        $display("FAIL stall_hold%0d: got PC=%0d fv=%b, required PC=6 fv=1",
                 i, bus.PC, bus.fetch_valid);
        n_err++;
      end
    end
    bus.stall   = 1'b0;
    bus.jump_en = 1'b0;
    step();
    n_cmp++;
    if (bus.PC !== 10'd7) begin
      $display("FAIL stall_release: got PC=%0d, required PC=7", bus.PC);
      n_err++;
    end
  endtask

  task automatic test_last_addr_jump();
    bus.jump_en    = 1'b1;
    bus.immOrLUT   = 1'b0;
    bus.target_idx = 4'b1110;
    step();
    n_cmp++;
    if (bus.PC !== 10'd5) begin
      $display("FAIL to_last: got PC=%0d, required PC=5", bus.PC);
      n_err++;
    end
    bus.target_idx = 4'b0001;
    step();
    bus.jump_en = 1'b0;
    n_cmp++;
    if ({bus.PC, bus.fetch_valid, bus.Done} !== {10'd6, 1'b1, 1'b0}) begin
      $display("FAIL last_jump_taken: got PC=%0d fv=%b done=%b, required PC=6 fv=1 done=0",
               bus.PC, bus.fetch_valid, bus.Done);
      n_err++;
    end
  endtask

  task automatic test_reset_mid_run();
    bus.jump_en    = 1'b1;
    bus.immOrLUT   = 1'b1;
    bus.target_idx = 4'd2;
    step();
    n_cmp++;
    if (bus.PC !== 10'd42) begin
      $display("FAIL mid_setup: got PC=%0d, required PC=42", bus.PC);
      n_err++;
    end
    bus.target_idx = 4'd3;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    idle_inputs();
    n_cmp++;
    if ({bus.PC, bus.fetch_valid, bus.Done} !== {10'd0, 1'b0, 1'b0}) begin
      $display("FAIL mid_reset: got PC=%0d fv=%b done=%b, required PC=0 fv=0 done=0",
               bus.PC, bus.fetch_valid, bus.Done);
      n_err++;
    end
    bus.Start = 1'b1;
    step();
    bus.Start      = 1'b0;
    bus.jump_en    = 1'b1;
    bus.immOrLUT   = 1'b1;
    bus.target_idx = 4'd3;
    step();
    n_cmp++;
    if (bus.PC !== 10'd0) begin
      $display("FAIL lut3_cleared: got PC=%0d, required PC=0", bus.PC);
      n_err++;
    end
    bus.target_idx = 4'd2;
    step();
    n_cmp++;
    if (bus.PC !== 10'd0) begin
      $display("FAIL lut2_cleared: got PC=%0d, required PC=0", bus.PC);
      n_err++;
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_done_restart();
    test_start_ignored();
    test_rel_jump();
    test_lut();
    test_stall();
    test_last_addr_jump();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Program-counter and fetch sequencer that sits directly upstream of the control decoder.
- Holds the PC that addresses instruction memory and supplies the opcode stream.
- Consumes the decoder's branch outputs, jump_en and immOrLUT, to choose the next PC: sequential, PC-relative immediate, or branch lookup table (LUT).
- Owns the program start/done handshake with the testbench/top level.

Parameters:
- PC_W, 10, PC width in bits; the PC wraps modulo 2^PC_W.
- LUT_DEPTH, 16, number of branch-target LUT entries; index width is 4.
- LAST_ADDR, 1023, address of the final program instruction; retiring it without a jump ends the program.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  single-cycle pulse that begins program execution at PC 0.
- stall  in  1  holds the PC for the current cycle.
- jump_en  in  1  taken-branch indication from the control decoder.
- immOrLUT  in  1  branch target source: 0 selects the relative immediate, 1 selects the LUT entry.
- target_idx  in  4  instruction low field, used as the signed offset or the LUT index.
- lut_we  in  1  LUT write enable.
- lut_waddr  in  4  LUT write address.
- lut_wdata  in  PC_W  LUT write data (absolute target).
- PC  out  PC_W  current instruction address.
- fetch_valid  out  1  PC addresses a live instruction.
- Done  out  1  program finished.

Behaviour:
- Clk and Reset: one clock, Clk; Reset is synchronous and active-high. Reset has priority over every other input at each edge.
- Reset values:
  - state=IDLE, PC=0, fetch_valid=0, Done=0.
  - All LUT entries are set to 0.
  - Reset asserted mid-RUN returns to IDLE at the next edge; any in-flight jump is discarded.
- States: IDLE, RUN, DONE. All outputs are registered, decoded from state and the PC register.
- IDLE:
  - fetch_valid=0, Done=0, PC=0.
  - Start=1 -> RUN; PC=0 at the next edge.
- RUN:
  - fetch_valid=1.
  - If stall=1: PC holds, jump_en is ignored, no state change.
  - Otherwise the next PC is chosen in this priority:
    - jump_en=1 and immOrLUT=1: PC <= LUT[target_idx].
    - jump_en=1 and immOrLUT=0: PC <= PC + signext(target_idx). The offset range is -8..+7. Offset 0 is a legal branch-to-self.
    - jump_en=0: PC <= PC+1.
  - All additions wrap modulo 2^PC_W: PC=0 with offset -1 goes to 2^PC_W-1.
  - End of program: if PC==LAST_ADDR, stall=0 and jump_en=0, go to DONE instead of incrementing. PC holds LAST_ADDR.
  - If PC==LAST_ADDR and jump_en=1, the jump is taken and the state stays RUN.
  - Start in RUN is ignored.
- DONE:
  - Done=1, fetch_valid=0, PC holds.
  - Start=1 -> RUN with PC=0; Done falls at the same edge.
- Latency: a branch decision presented in cycle N is visible on PC in cycle N+1. No delay slot.
- LUT:
  - Written synchronously in any state, including IDLE and DONE.
  - Read is combinational from the registered array.
  - Same-cycle write and jump read of the same index: the jump uses the old value; the new value is visible from the next cycle.
- Inputs jump_en, immOrLUT and target_idx are don't-care outside RUN.

Test Plan:
- Reset, Start pulse, no jumps, LAST_ADDR=5 -> PC 0,1,2,3,4,5 in successive cycles with fetch_valid=1; Done=1 in the cycle after PC=5 is retired; PC holds 5.
- At PC=10: jump_en=1, immOrLUT=0, target_idx=4'b1101 -> PC=7 next cycle. At PC=0: target_idx=4'b1111 -> PC=1023 (wrap).
- lut_we writes LUT[3]=200; jump_en=1, immOrLUT=1, target_idx=3 -> PC=200. A same-cycle write LUT[3]=300 with a jump via index 3 -> PC=200, not 300.
- stall=1 held 3 cycles at PC=6 with jump_en=1 asserted -> PC stays 6. After stall drops with jump_en=0 -> PC=7.
- Reset asserted while RUN at PC=42 -> next cycle IDLE with PC=0, fetch_valid=0, Done=0; LUT reads back 0.
- In DONE, Start pulse -> Done=0 and PC=0 next cycle. Start during RUN at PC=3 -> ignored, PC=4.
